// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  typedef enum logic [2:0] {
    S_MODE, S_OP, S_SIZE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WAIT, S_OUT
  } state_t;

  // Prompt IDs understood by the UART text engine
  localparam logic [2:0] PR_MODE   = 3'd0;
  localparam logic [2:0] PR_OP     = 3'd1;
  localparam logic [2:0] PR_SIZE   = 3'd2;
  localparam logic [2:0] PR_A      = 3'd3;
  localparam logic [2:0] PR_B      = 3'd4;
  localparam logic [2:0] PR_RESULT = 3'd5;
  localparam logic [2:0] PR_ERROR  = 3'd6;

  // Modes 0..NU-1 are execution units; the two above them are register ops
  function automatic int mode_fetch(input int nu);
    return nu;
  endfunction

  function automatic int mode_store(input int nu);
    return nu + 1;
  endfunction

  // Width of the mode field
  function automatic int calc_mw(input int nu);
    return $clog2(nu + 2);
  endfunction

  // Width of the word counter / size field (never zero)
  function automatic int calc_kw(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

  // Register file address width (never zero)
  function automatic int calc_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/calc_regfile.sv
// NREG x DW register file: synchronous write, combinational read, sync clear.
// Latency: write visible the cycle after we; read is same-cycle.
// Backpressure: none, always accepts.
// Ports: clk, rst, we/waddr/wdata write port, raddr/rdata read port.
module calc_regfile
  import calc_pkg::*;
#(
  parameter int DW   = 64,
  parameter int NREG = 4,
  parameter int AW   = calc_aw(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/calc_sequencer.sv
// Menu-driven operand entry and dispatch: collects mode/op/size/operands from
// button presses, runs one unit (start/done, with timeout) or a register op.
// Latency: one press per field; unit result reaches OUT the cycle after done.
// Backpressure: result held in OUT until result_ready; presses ignored while busy.
// Ports: btn_pulse/sw/unary in; unit_start/unit_op/opa/opb to units,
// unit_done/unit_result back; result/result_valid/result_ready/sign/error to
// the UART formatter; prompt_id/prompt_valid to the text engine; busy.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DW      = 64,
  parameter int SW      = 16,
  parameter int NU      = 4,
  parameter int NREG    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_pulse,
  input  logic [SW-1:0]    sw,
  input  logic             unary,
  output logic [NU-1:0]    unit_start,
  output logic [2:0]       unit_op,
  output logic [DW-1:0]    opa,
  output logic [DW-1:0]    opb,
  input  logic [NU-1:0]    unit_done,
  input  logic [NU*DW-1:0] unit_result,
  output logic [DW-1:0]    result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             sign,
  output logic             error,
  output logic [2:0]       prompt_id,
  output logic             prompt_valid,
  output logic             busy
);

  localparam int NW = DW / SW;
  localparam int MW = calc_mw(NU);
  localparam int KW = calc_kw(NW);
  localparam int AW = calc_aw(NREG);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [MW-1:0] M_FETCH = MW'(mode_fetch(NU));
  localparam logic [MW-1:0] M_STORE = MW'(mode_store(NU));

  state_t        state_q, state_n;
  logic [MW-1:0] mode_q, mode_n;
  logic [2:0]    op_q, op_n;
  logic [KW-1:0] last_q, last_n;   // index of the last operand word
  logic [KW-1:0] k_q, k_n;
  logic [DW-1:0] opa_q, opa_n, opb_q, opb_n, res_q, res_n;
  logic          rv_q, rv_n, err_q, err_n, pv_q, pv_n;
  logic [2:0]    pid_q, pid_n;
  logic          again_q, again_n; // announce the MODE prompt next cycle
  logic [TW-1:0] tmo_q, tmo_n;

  logic          press, done_sel, rf_we;
  logic [DW-1:0] res_sel, rf_rdata;

  // A press coinciding with a prompt pulse is dropped
  assign press = btn_pulse && !pv_q;

  calc_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (op_q[AW-1:0]),
    .wdata (opa_n),
    .raddr (sw[AW-1:0]),
    .rdata (rf_rdata)
  );

  // Unit selection by mode; fetch/store modes match no unit
  always_comb begin
    done_sel   = 1'b0;
    res_sel    = '0;
    unit_start = '0;
    sign       = 1'b0;
    for (int i = 0; i < NU; i++) begin
      if (mode_q == MW'(i)) begin
        done_sel      = unit_done[i];
        res_sel       = unit_result[i*DW +: DW];
        unit_start[i] = (state_q == S_EXEC);
      end
    end
    for (int i = 0; i < NW; i++) begin
      if (last_q == KW'(i)) sign = res_q[i*SW + SW - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_MODE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    op_n    = op_q;
    last_n  = last_q;
    k_n     = k_q;
    opa_n   = opa_q;
    opb_n   = opb_q;
    res_n   = res_q;
    rv_n    = rv_q;
    err_n   = err_q;
    tmo_n   = tmo_q;
    pv_n    = 1'b0;
    pid_n   = pid_q;
    again_n = 1'b0;
    rf_we   = 1'b0;

    if (again_q) begin
      pv_n  = 1'b1;
      pid_n = PR_MODE;
    end

    case (state_q)
      S_MODE: if (press) begin
        if (sw[MW-1:0] > M_STORE) begin
          pv_n    = 1'b1;
          pid_n   = PR_ERROR;
          again_n = 1'b1;
        end else begin
          mode_n  = sw[MW-1:0];
          state_n = S_OP;
        end
      end
      S_OP: if (press) begin
        op_n = sw[2:0];
        if (mode_q == M_FETCH) begin
          last_n = KW'(NW - 1);
          if (32'(sw[2:0]) < NREG) begin
            res_n = rf_rdata;
            err_n = 1'b0;
          end else begin
            res_n = '0;
            err_n = 1'b1;
          end
          rv_n    = 1'b1;
          state_n = S_OUT;
        end else begin
          state_n = S_SIZE;
        end
      end
      S_SIZE: if (press) begin
        if (32'(sw[KW-1:0]) > NW - 1) last_n = KW'(NW - 1);
        else                          last_n = sw[KW-1:0];
        opa_n   = '0;
        opb_n   = '0;
        k_n     = '0;
        state_n = S_LOAD_A;
      end
      S_LOAD_A: if (press) begin
        for (int i = 0; i < NW; i++) begin
          if (k_q == KW'(i)) opa_n[i*SW +: SW] = sw;
        end
        k_n = k_q + KW'(1);
        if (k_q == last_q) begin
          k_n = '0;
          if (mode_q == M_STORE) begin
            if (32'(op_q) < NREG) begin
              rf_we = 1'b1;
              res_n = opa_n;
              err_n = 1'b0;
            end else begin
              res_n = '0;
              err_n = 1'b1;
            end
            rv_n    = 1'b1;
            state_n = S_OUT;
          end else if (unary) begin
            state_n = S_EXEC;
          end else begin
            state_n = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: if (press) begin
        for (int i = 0; i < NW; i++) begin
          if (k_q == KW'(i)) opb_n[i*SW +: SW] = sw;
        end
        k_n = k_q + KW'(1);
        if (k_q == last_q) begin
          k_n     = '0;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        tmo_n   = TW'(TIMEOUT - 1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over expiry in the final cycle
        if (done_sel) begin
          res_n   = res_sel;
          err_n   = 1'b0;
          rv_n    = 1'b1;
          state_n = S_OUT;
        end else if (tmo_q == '0) begin
          res_n   = '0;
          err_n   = 1'b1;
          rv_n    = 1'b1;
          state_n = S_OUT;
        end else begin
          tmo_n = tmo_q - TW'(1);
        end
      end
      S_OUT: if (result_ready) begin
        rv_n    = 1'b0;
        state_n = S_MODE;
      end
      default: state_n = S_MODE;
    endcase

    // Prompt pulse on entry to any operator-facing state
    if (state_n != state_q) begin
      case (state_n)
        S_MODE:   begin pv_n = 1'b1; pid_n = PR_MODE; end
        S_OP:     begin pv_n = 1'b1; pid_n = PR_OP;   end
        S_SIZE:   begin pv_n = 1'b1; pid_n = PR_SIZE; end
        S_LOAD_A: begin pv_n = 1'b1; pid_n = PR_A;    end
        S_LOAD_B: begin pv_n = 1'b1; pid_n = PR_B;    end
        S_OUT:    begin pv_n = 1'b1; pid_n = err_n ? PR_ERROR : PR_RESULT; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      op_q    <= '0;
      last_q  <= '0;
      k_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      pv_q    <= 1'b0;
      pid_q   <= '0;
      again_q <= 1'b1;   // first cycle out of reset announces MODE
      tmo_q   <= '0;
    end else begin
      mode_q  <= mode_n;
      op_q    <= op_n;
      last_q  <= last_n;
      k_q     <= k_n;
      opa_q   <= opa_n;
      opb_q   <= opb_n;
      res_q   <= res_n;
      rv_q    <= rv_n;
      err_q   <= err_n;
      pv_q    <= pv_n;
      pid_q   <= pid_n;
      again_q <= again_n;
      tmo_q   <= tmo_n;
    end
  end

  assign unit_op      = op_q;
  assign opa          = opa_q;
  assign opb          = opb_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign error        = err_q;
  assign prompt_id    = pid_q;
  assign prompt_valid = pv_q;
  assign busy         = (state_q == S_EXEC) || (state_q == S_WAIT) || (state_q == S_OUT);

endmodule
